regfile_writeback_queue: RTL and testbench

//  Writer-side companion to the 32x64 register file: buffers pending

---
 rtl/regwb_pkg.sv | 18 +
 rtl/regwb_lookup.sv | 45 ++++
 rtl/regfile_writeback_queue.sv | 139 +++++++++++++
 tb/tb_regfile_writeback_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// -----------------------------------------------------------------------------
// regwb_pkg
// Shared types and constants for the register-file writeback queue.
//   ADDR_W      : register index width (32 architectural registers)
//   DATA_W      : writeback data width (matches the 64-bit register file)
//   wb_entry_t  : one pending writeback, destination index plus value
// -----------------------------------------------------------------------------
package regwb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage : regwb_pkg

// File: rtl/regwb_lookup.sv
// -----------------------------------------------------------------------------
// regwb_lookup
// Bypass match for the writeback queue: finds the youngest occupied entry
// whose destination register equals the requested index. Purely combinational.
// Only instantiated when the top is built with WB_BYPASS_EN.
//   entries_i : queue storage, indexed by physical slot
//   valid_i   : one bit per slot, 1 = slot currently occupied
//   wr_idx_i  : physical slot the next push will use (youngest is wr_idx_i-1)
//   reg_i     : register index being read by the operand stage
//   hit_o     : a queued write to reg_i is pending
//   data_o    : youngest queued value for reg_i, 0 when no hit
// -----------------------------------------------------------------------------
module regwb_lookup
  import regwb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  wb_entry_t         entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] reg_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: every output of a combinational block is given a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin : match
    logic [IDX_W-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    // Walk from the youngest slot towards the oldest; the first match wins so
    // a later write to the same register shadows earlier ones.
    for (int k = 0; k < DEPTH; k++) begin
      idx = wr_idx_i - IDX_W'(k + 1);
      if (!hit_o && valid_i[idx] && (entries_i[idx].rd == reg_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule : regwb_lookup

// File: rtl/regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// regfile_writeback_queue
// Buffers destination-register writebacks from execute/memory producers and
// drains them in strict order, one per cycle, onto the register-file write
// port. Optional bypass lookup (build macro WB_BYPASS_EN) lets operand reads
// see values still waiting in the queue.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   push_valid/ready     producer handshake; ready = !full (registered only)
//   push_reg, push_data  destination register and value to queue
//   drain_en             register-file write port is free this cycle
//   wb_en/wb_reg/wb_data regWrite / writeRegister / writeData (head entry)
//   count                number of occupied entries
//   lk_reg1/2            bypass lookup indices          (WB_BYPASS_EN only)
//   lk_hit1/2, lk_data1/2 pending-write hit and youngest value (WB_BYPASS_EN)
// -----------------------------------------------------------------------------
module regfile_writeback_queue
  import regwb_pkg::wb_entry_t;
#(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = regwb_pkg::DATA_W,
  parameter int  ADDR_W = regwb_pkg::ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH) + 1,
  localparam int IDX_W  = PTR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              drain_en,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [PTR_W-1:0]  count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] lk_reg1,
  input  logic [ADDR_W-1:0] lk_reg2,
  output logic              lk_hit1,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data1,
  output logic [DATA_W-1:0] lk_data2
`endif
);

  // Entry storage is the shared packed struct, so the widths must agree.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 2");
  end
  if (DATA_W != regwb_pkg::DATA_W || ADDR_W != regwb_pkg::ADDR_W) begin : g_width_chk
    $error("DATA_W/ADDR_W must match regwb_pkg");
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        head;
  logic             empty, full, push_fire, pop_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[PTR_W-1] != wr_ptr_q[PTR_W-1]) &&
                 (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]);

  // Ready looks at registered state only: a same-cycle drain never lets a
  // push into a full queue, which keeps ready off the drain_en timing path.
  assign push_ready = !full;
  assign push_fire  = push_valid && push_ready;
  assign wb_en      = !empty && drain_en;
  assign pop_fire   = wb_en;

  assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign wb_reg  = empty ? '0 : head.rd;
  assign wb_data = empty ? '0 : head.data;
  assign count   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: the entry array has no reset; occupancy is defined by the pointers
  // alone, and every read of a slot is qualified by it, so stale contents are
  // never observable. Leaving the array unreset lets it map onto plain flops
  // or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= '{rd: push_reg, data: push_data};
    end
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0] slot_valid;

  // Slot i is occupied when its distance from the head is below the count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, IDX_W'(i) - rd_ptr_q[IDX_W-1:0]} < count);
    end
  end

  regwb_lookup #(.DEPTH(DEPTH)) u_lookup1 (
    .entries_i (mem_q),
    .valid_i   (slot_valid),
    .wr_idx_i  (wr_ptr_q[IDX_W-1:0]),
    .reg_i     (lk_reg1),
    .hit_o     (lk_hit1),
    .data_o    (lk_data1)
  );

  regwb_lookup #(.DEPTH(DEPTH)) u_lookup2 (
    .entries_i (mem_q),
    .valid_i   (slot_valid),
    .wr_idx_i  (wr_ptr_q[IDX_W-1:0]),
    .reg_i     (lk_reg2),
    .hit_o     (lk_hit2),
    .data_o    (lk_data2)
  );
`endif

endmodule : regfile_writeback_queue

// File: tb/tb_regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_queue
// Self-checking bench for regfile_writeback_queue (DEPTH=4). A queue-based
// reference model tracks the pending writebacks; lookup checks are compiled
// in when WB_BYPASS_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ref_entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [4:0]  push_reg;
  logic [63:0] push_data;
  logic        drain_en;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic [2:0]  count;
  logic [4:0]  lk_reg1, lk_reg2;
  logic        lk_hit1, lk_hit2;
  logic [63:0] lk_data1, lk_data2;

  ref_entry_t  model_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_reg   (push_reg),
    .push_data  (push_data),
    .drain_en   (drain_en),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .count      (count)
`ifdef WB_BYPASS_EN
    ,
    .lk_reg1    (lk_reg1),
    .lk_reg2    (lk_reg2),
    .lk_hit1    (lk_hit1),
    .lk_hit2    (lk_hit2),
    .lk_data1   (lk_data1),
    .lk_data2   (lk_data2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Youngest queued value for a register, straight from the model queue.
  task automatic model_lookup(input logic [4:0] r, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].rd == r) begin
        hit = 1'b1;
        d   = model_q[i].data;
        break;
      end
    end
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic compare_outputs(input string tag);
    int          n;
    logic        h;
    logic [63:0] d;
    n = model_q.size();
    check({tag, ".count"},      64'(count),      64'(n));
    check({tag, ".push_ready"}, 64'(push_ready), 64'(n < DEPTH));
    check({tag, ".wb_en"},      64'(wb_en),      64'(n > 0 && drain_en));
    check({tag, ".wb_reg"},     64'(wb_reg),     (n > 0) ? 64'(model_q[0].rd) : 64'd0);
    check({tag, ".wb_data"},    wb_data,         (n > 0) ? model_q[0].data : 64'd0);
`ifdef WB_BYPASS_EN
    model_lookup(lk_reg1, h, d);
    check({tag, ".lk_hit1"},  64'(lk_hit1), 64'(h));
    check({tag, ".lk_data1"}, lk_data1,     d);
    model_lookup(lk_reg2, h, d);
    check({tag, ".lk_hit2"},  64'(lk_hit2), 64'(h));
    check({tag, ".lk_data2"}, lk_data2,     d);
`else
    h = 1'b0;
    d = '0;
`endif
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance model.
  task automatic step(input string tag, input logic pv, input logic [4:0] preg,
                      input logic [63:0] pdata, input logic de,
                      input logic [4:0] l1, input logic [4:0] l2);
    bit acc, pop;
    push_valid = pv;
    push_reg   = preg;
    push_data  = pdata;
    drain_en   = de;
    lk_reg1    = l1;
    lk_reg2    = l2;
    @(negedge clk);
    compare_outputs(tag);
    acc = pv && (model_q.size() < DEPTH);
    pop = de && (model_q.size() > 0);
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back('{rd: preg, data: pdata});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles, input logic de);
    reset      = 1'b1;
    push_valid = 1'b0;
    drain_en   = de;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; push_valid = 1'b0; push_reg = '0; push_data = '0;
    drain_en = 1'b0; lk_reg1 = '0; lk_reg2 = '0;
    @(posedge clk);
    #1;

    // 1: reset state
    do_reset(2, 1'b0);
    check("t1.count", 64'(count), 64'd0);
    check("t1.push_ready", 64'(push_ready), 64'd1);
    step("t1", 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd1);

    // 2: single push, one-cycle latency, then empty
    step("t2.push", 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1, 5'd5, 5'd0);
    step("t2.wb",   1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd0);
    check("t2.wb_reg_after", 64'(wb_reg), 64'd0);
    step("t2.idle", 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd0);

    // 3: fill to DEPTH, 5th push refused, ordered drain
    for (int i = 1; i <= 5; i++)
      step("t3.fill", 1'b1, 5'(i), 64'(i) * 64'h1111, 1'b0, 5'(i), 5'd5);
    check("t3.count_full", 64'(count), 64'd4);
    check("t3.ready_full", 64'(push_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      push_valid = 1'b0;
      drain_en   = 1'b1;
      #1;
      check("t3.order", 64'(wb_reg), 64'(i));
      step("t3.drain", 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd4);
    end

    // 4: full + simultaneous push/drain: push refused, then accepted
    for (int i = 0; i < 4; i++)
      step("t4.fill", 1'b1, 5'(10 + i), 64'(100 + i), 1'b0, 5'd10, 5'd13);
    step("t4.refuse", 1'b1, 5'd20, 64'hAAAA, 1'b1, 5'd20, 5'd11);
    check("t4.count_after_refuse", 64'(count), 64'd3);
    step("t4.accept", 1'b1, 5'd21, 64'hBBBB, 1'b1, 5'd21, 5'd20);
    check("t4.count_after_accept", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++)
      step("t4.drain", 1'b0, 5'd0, 64'd0, 1'b1, 5'd21, 5'd13);

    // 5: same register queued twice; youngest value wins, other index misses
    step("t5.a", 1'b1, 5'd7, 64'hA, 1'b0, 5'd7, 5'd8);
    step("t5.b", 1'b1, 5'd7, 64'hB, 1'b0, 5'd7, 5'd8);
    step("t5.look", 1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd8);
    step("t5.look31", 1'b1, 5'd31, 64'h3131, 1'b0, 5'd31, 5'd7);

    // 6: reset mid-drain with three entries queued
    do_reset(1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("t6.fill", 1'b1, 5'(24 + i), 64'(200 + i), 1'b0, 5'd24, 5'd25);
    step("t6.draining", 1'b0, 5'd0, 64'd0, 1'b1, 5'd25, 5'd26);
    do_reset(1, 1'b1);
    check("t6.count_reset", 64'(count), 64'd0);
    check("t6.wb_en_reset", 64'(wb_en), 64'd0);
    step("t6.push2", 1'b1, 5'd2, 64'h2222, 1'b1, 5'd2, 5'd25);
    check("t6.first_reg", 64'(wb_reg), 64'd2);
    step("t6.drain2", 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 5'd25);

    // Randomised traffic, small register range so lookups hit often
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1, 1'($urandom_range(0, 1)));
      end else begin
        step("rnd",
             1'($urandom_range(0, 99) < 60),
             5'($urandom_range(0, 7)),
             {$urandom, $urandom},
             1'($urandom_range(0, 99) < 45),
             5'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_writeback_queue
